// File: rtl/ecc_point_add_ctrl.sv
// Sequencer for affine point addition R = P + Q over GF(p). All field
// arithmetic runs on an external GFAU; this block issues ops and moves results.
module ecc_point_add_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_x1,
  input  logic [31:0] i_y1,
  input  logic [31:0] i_x2,
  input  logic [31:0] i_y2,
  input  logic [31:0] i_prime,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_x3,
  output logic [31:0] o_y3,
  output logic [31:0] o_gf_in0,
  output logic [31:0] o_gf_in1,
  output logic [31:0] o_gf_prime,
  output logic [1:0]  o_gf_op,
  output logic        o_gf_dfc,
  input  logic [31:0] i_gf_result,
  input  logic        i_gf_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACK, S_FIN} state_e;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [3:0] LAST_STEP = 4'd8;

  state_e      state_q;
  logic [3:0]  step_q;
  logic [31:0] x1_q, y1_q, x2_q;
  logic [31:0] t0_q, t1_q, l_q, t2_q, x3_q, y3_q;
  logic [31:0] gf_in0_q, gf_in1_q, gf_prime_q;
  logic [1:0]  gf_op_q;
  logic        busy_q, done_q, err_q, dfc_q;

  logic [3:0]  step_d;
  logic [1:0]  nxt_op;
  logic [31:0] nxt_in0, nxt_in1;

  assign step_d = step_q + 4'd1;

  // Operands for the step about to be issued out of ACK. Step 0 is issued
  // straight from the input ports when a start is accepted.
  always_comb begin
    nxt_op  = OP_SUB;
    nxt_in0 = '0;
    nxt_in1 = '0;
    case (step_d)
      4'd1: begin nxt_op = OP_SUB; nxt_in0 = x2_q; nxt_in1 = x1_q; end
      4'd2: begin nxt_op = OP_DIV; nxt_in0 = t0_q; nxt_in1 = t1_q; end
      4'd3: begin nxt_op = OP_MUL; nxt_in0 = l_q;  nxt_in1 = l_q;  end
      4'd4: begin nxt_op = OP_SUB; nxt_in0 = t2_q; nxt_in1 = x1_q; end
      4'd5: begin nxt_op = OP_SUB; nxt_in0 = t2_q; nxt_in1 = x2_q; end
      4'd6: begin nxt_op = OP_SUB; nxt_in0 = x1_q; nxt_in1 = x3_q; end
      4'd7: begin nxt_op = OP_MUL; nxt_in0 = l_q;  nxt_in1 = t2_q; end
      4'd8: begin nxt_op = OP_SUB; nxt_in0 = t2_q; nxt_in1 = y1_q; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      l_q        <= '0;
      t2_q       <= '0;
      x3_q       <= '0;
      y3_q       <= '0;
      gf_in0_q   <= '0;
      gf_in1_q   <= '0;
      gf_prime_q <= '0;
      gf_op_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dfc_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            x1_q   <= i_x1;
            y1_q   <= i_y1;
            x2_q   <= i_x2;
            step_q <= '0;
            busy_q <= 1'b1;
            if (i_x1 == i_x2) begin
              err_q   <= 1'b1;
              x3_q    <= '0;
              y3_q    <= '0;
              state_q <= S_FIN;
            end else begin
              err_q      <= 1'b0;
              gf_op_q    <= OP_SUB;
              gf_in0_q   <= i_y2;
              gf_in1_q   <= i_y1;
              gf_prime_q <= i_prime;
              state_q    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_gf_done) begin
            case (step_q)
              4'd0:    t0_q <= i_gf_result;
              4'd1:    t1_q <= i_gf_result;
              4'd2:    l_q  <= i_gf_result;
              4'd5:    x3_q <= i_gf_result;
              4'd8:    y3_q <= i_gf_result;
              default: t2_q <= i_gf_result;
            endcase
            dfc_q   <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          dfc_q <= 1'b0;
          if (step_q == LAST_STEP) begin
            gf_op_q    <= '0;
            gf_in0_q   <= '0;
            gf_in1_q   <= '0;
            gf_prime_q <= '0;
            done_q     <= 1'b1;
            state_q    <= S_FIN;
          end else begin
            step_q   <= step_d;
            gf_op_q  <= nxt_op;
            gf_in0_q <= nxt_in0;
            gf_in1_q <= nxt_in1;
            state_q  <= S_RUN;
          end
        end
        S_FIN: begin
          // The degenerate path arrives with done low and spends one extra
          // cycle here before pulsing, giving its fixed two-cycle latency.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_x3       = x3_q;
  assign o_y3       = y3_q;
  assign o_gf_in0   = gf_in0_q;
  assign o_gf_in1   = gf_in1_q;
  assign o_gf_prime = gf_prime_q;
  assign o_gf_op    = gf_op_q;
  assign o_gf_dfc   = dfc_q;

endmodule

// File: tb/tb_ecc_point_add_ctrl.sv
// Randomized bench for ecc_point_add_ctrl: a behavioural GFAU with
// programmable latency plus a closed-form point-addition reference.
module tb_ecc_point_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, prime = '0;
  logic        o_busy, o_done, o_err, o_gf_dfc;
  logic [31:0] o_x3, o_y3, o_gf_in0, o_gf_in1, o_gf_prime;
  logic [1:0]  o_gf_op;
  logic [31:0] gf_res = '0;
  logic        gf_done = 1'b0;
  logic        spur = 1'b0;

  int total = 0;
  int bad = 0;
  int gf_delay = 0;
  int hold_bad = 0;
  int m_cnt = 0;
  int m_stp = 0;
  logic [97:0] m_snap;
  logic [1:0]  log_op [0:8];
  logic [31:0] log_in0 [0:8];
  logic [31:0] log_in1 [0:8];

  ecc_point_add_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2), .i_prime(prime),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_x3(o_x3), .o_y3(o_y3),
    .o_gf_in0(o_gf_in0), .o_gf_in1(o_gf_in1), .o_gf_prime(o_gf_prime),
    .o_gf_op(o_gf_op), .o_gf_dfc(o_gf_dfc),
    .i_gf_result(gf_res), .i_gf_done(gf_done | spur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_add(input logic [31:0] a, b, p);
    longint unsigned s;
    s = (longint'(a) + longint'(b)) % longint'(p);
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] a, b, p);
    longint unsigned s;
    s = (longint'(a) + longint'(p) - longint'(b)) % longint'(p);
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, b, p);
    longint unsigned s;
    s = (longint'(a) * longint'(b)) % longint'(p);
    return s[31:0];
  endfunction

  // Inverse via Fermat: b^(p-2) mod p, p prime.
  function automatic logic [31:0] m_inv(input logic [31:0] b, p);
    logic [31:0] r, base, e;
    r = 32'd1; base = b % p; e = p - 32'd2;
    for (int i = 0; i < 32; i++) begin
      if (e[0]) r = m_mul(r, base, p);
      base = m_mul(base, base, p);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] gf_calc(input logic [1:0] op, input logic [31:0] a, b, p);
    if (p == 0) return 32'd0;
    case (op)
      2'b00:   return m_add(a, b, p);
      2'b01:   return m_sub(a, b, p);
      2'b10:   return m_mul(a, b, p);
      default: return m_mul(a, m_inv(b, p), p);
    endcase
  endfunction

  // GFAU model: answers gf_delay cycles after an op appears, drops on ack.
  always @(negedge clk) begin
    if (!rst_n || !o_busy || o_done) begin
      gf_done = 1'b0; m_cnt = 0; m_stp = 0;
    end else if (o_gf_dfc) begin
      gf_done = 1'b0; m_cnt = 0; m_stp++;
    end else if (!gf_done) begin
      if (m_cnt == 0) begin
        m_snap = {o_gf_op, o_gf_in0, o_gf_in1, o_gf_prime};
        if (m_stp < 9) begin
          log_op[m_stp] = o_gf_op; log_in0[m_stp] = o_gf_in0; log_in1[m_stp] = o_gf_in1;
        end
      end else if ({o_gf_op, o_gf_in0, o_gf_in1, o_gf_prime} != m_snap) begin
        hold_bad++;
      end
      if (m_cnt >= gf_delay) begin
        gf_done = 1'b1;
        gf_res = gf_calc(o_gf_op, o_gf_in0, o_gf_in1, o_gf_prime);
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic ref_add(input logic [31:0] p, ax1, ay1, ax2, ay2,
                         output logic [31:0] rx3, ry3, output logic rerr);
    logic [31:0] lam;
    if (ax1 == ax2) begin
      rx3 = 0; ry3 = 0; rerr = 1'b1;
    end else begin
      lam  = m_mul(m_sub(ay2, ay1, p), m_inv(m_sub(ax2, ax1, p), p), p);
      rx3  = m_sub(m_sub(m_mul(lam, lam, p), ax1, p), ax2, p);
      ry3  = m_sub(m_mul(lam, m_sub(ax1, rx3, p), p), ay1, p);
      rerr = 1'b0;
    end
  endtask

  function automatic logic any_out();
    return |{o_busy, o_done, o_err, o_gf_dfc, o_gf_op, o_x3, o_y3,
             o_gf_in0, o_gf_in1, o_gf_prime};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("rst_async_zero", any_out(), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_zero", any_out(), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {o_busy, o_done, o_gf_dfc}, 0);
    end
  endtask

  // Issues one start; optional re-start injection at step inj and reset at step rst_at.
  task automatic run(input logic [31:0] p, ax1, ay1, ax2, ay2, input int dly,
                     input int inj, input int rst_at,
                     output int cyc, output int dfcs, output bit aborted);
    bit injected;
    gf_delay = dly; hold_bad = 0; aborted = 0; injected = 0;
    @(negedge clk);
    prime = p; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; dfcs = 0;
    while (1) begin
      if (o_gf_dfc) dfcs++;
      if (o_done) break;
      if (cyc >= 2000) begin chk("timeout", cyc, 0); break; end
      if (rst_at >= 0 && dfcs == rst_at && !o_gf_dfc) begin
        do_reset(); aborted = 1; break;
      end
      if (start) start = 1'b0;
      else if (inj >= 0 && dfcs == inj && !o_gf_dfc && !injected) begin
        injected = 1; start = 1'b1;
        x1 = 32'd1; y1 = 32'd2; x2 = 32'd4; y2 = 32'd8;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  int cyc, dfcs;
  bit ab;
  logic [31:0] ex3, ey3, rp, rx1, ry1, rx2, ry2;
  logic eerr;
  logic [31:0] primes [0:4];

  initial begin
    primes[0] = 32'd23; primes[1] = 32'd97; primes[2] = 32'd65521;
    primes[3] = 32'h7fff_ffff; primes[4] = 32'hffff_fffb;

    repeat (3) @(negedge clk);
    chk("reset_state", any_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference example, zero-wait GFAU
    run(23, 3, 10, 9, 7, 0, -1, -1, cyc, dfcs, ab);
    chk("ex_latency", cyc, 19);
    chk("ex_x3", o_x3, 32'h11);
    chk("ex_y3", o_y3, 32'h14);
    chk("ex_err", o_err, 0);
    chk("ex_dfc_count", dfcs, 9);
    chk("ex_busy_at_done", o_busy, 1);
    chk("ex_gf_idle_at_done", |{o_gf_op, o_gf_in0, o_gf_in1, o_gf_prime}, 0);
    chk("ex_div_op", log_op[2], 2'b11);
    chk("ex_L_sq_op", log_op[3], 2'b10);
    chk("ex_L_in0", log_in0[3], 32'h0B);
    chk("ex_L_in1", log_in1[3], 32'h0B);
    @(negedge clk);
    chk("ex_done_pulse", {o_done, o_busy}, 0);
    chk("ex_x3_held", o_x3, 32'h11);

    // Slow GFAU: 5-cycle delay per op
    run(23, 3, 10, 9, 7, 5, -1, -1, cyc, dfcs, ab);
    chk("slow_latency", cyc, 64);
    chk("slow_result", {o_y3, o_x3}, {32'h14, 32'h11});
    chk("slow_hold", hold_bad, 0);
    chk("slow_dfc_count", dfcs, 9);

    // Degenerate x1 == x2
    run(23, 5, 4, 5, 19, 0, -1, -1, cyc, dfcs, ab);
    chk("deg_latency", cyc, 2);
    chk("deg_err", o_err, 1);
    chk("deg_result", {o_y3, o_x3}, 0);
    chk("deg_no_dfc", dfcs, 0);
    @(negedge clk);
    chk("deg_err_held", o_err, 1);
    chk("deg_gf_zero", |{o_gf_op, o_gf_in0, o_gf_in1, o_gf_prime}, 0);

    // Start re-pulsed mid-computation must be ignored
    run(23, 3, 10, 9, 7, 2, 4, -1, cyc, dfcs, ab);
    chk("inj_latency", cyc, 37);
    chk("inj_result", {o_y3, o_x3}, {32'h14, 32'h11});
    chk("inj_err", o_err, 0);
    repeat (2) @(negedge clk);
    chk("inj_no_restart", o_busy, 0);

    // Reset during step 6, then recompute
    run(23, 3, 10, 9, 7, 0, -1, 6, cyc, dfcs, ab);
    chk("rst_aborted", ab, 1);
    run(23, 3, 10, 9, 7, 0, -1, -1, cyc, dfcs, ab);
    chk("rst_rerun_latency", cyc, 19);
    chk("rst_rerun_result", {o_y3, o_x3}, {32'h14, 32'h11});

    // Spurious GFAU done while idle
    @(negedge clk);
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_idle", {o_busy, o_gf_dfc, o_done}, 0);
    end
    spur = 1'b0;
    chk("spur_x3_held", o_x3, 32'h11);

    // Randomized points, primes and GFAU latency
    for (int n = 0; n < 24; n++) begin
      int d;
      rp  = primes[$urandom_range(0, 4)];
      rx1 = $urandom % rp; ry1 = $urandom % rp;
      rx2 = $urandom % rp; ry2 = $urandom % rp;
      if ($urandom_range(0, 5) == 0) rx2 = rx1;
      d = $urandom_range(0, 3);
      ref_add(rp, rx1, ry1, rx2, ry2, ex3, ey3, eerr);
      run(rp, rx1, ry1, rx2, ry2, d, -1, -1, cyc, dfcs, ab);
      chk("rnd_result", {o_err, o_y3, o_x3}, {eerr, ey3, ex3});
      chk("rnd_latency", cyc, eerr ? 2 : 9 * (d + 2) + 1);
      chk("rnd_dfc_count", dfcs, eerr ? 0 : 9);
      chk("rnd_hold", hold_bad, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
